// File: rtl/array_io_ctrl_if.sv
// array_io_ctrl_if: host buffer access, run control and array IO PE data bundle.
interface array_io_ctrl_if #(
    parameter int SYS_DWIDTH = 32,
    parameter int DEPTH      = 256
);
    localparam int AW = $clog2(DEPTH);
    logic                  Start;
    logic [AW:0]           Cycle_Count;
    logic                  Done;
    logic [1:0]            Host_Sel;
    logic                  Host_We;
    logic [AW-1:0]         Host_Addr;
    logic [SYS_DWIDTH-1:0] Host_Wdata;
    logic [SYS_DWIDTH-1:0] Host_Rdata;
    logic [SYS_DWIDTH-1:0] Data0_Load;
    logic [SYS_DWIDTH-1:0] Data1_Load;
    logic [SYS_DWIDTH-1:0] Data0_Store;
    logic [SYS_DWIDTH-1:0] Data1_Store;
    logic                  PE_Array_Busy;
    modport master (
        output Start, Cycle_Count, Host_Sel, Host_We, Host_Addr, Host_Wdata, Data0_Store, Data1_Store,
        input  Done, Host_Rdata, Data0_Load, Data1_Load, PE_Array_Busy
    );
    modport slave (
        input  Start, Cycle_Count, Host_Sel, Host_We, Host_Addr, Host_Wdata, Data0_Store, Data1_Store,
        output Done, Host_Rdata, Data0_Load, Data1_Load, PE_Array_Busy
    );
endinterface

// File: rtl/array_io_ctrl.sv
// array_io_ctrl: streams two load buffers into the PE array and captures its two result streams.
module array_io_ctrl #(
    parameter int SYS_DWIDTH = 32,
    parameter int DEPTH      = 256
) (
    input logic            Clk,
    input logic            Reset,
    array_io_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state;
    logic [SYS_DWIDTH-1:0] load_buf0  [DEPTH];
    logic [SYS_DWIDTH-1:0] load_buf1  [DEPTH];
    logic [SYS_DWIDTH-1:0] store_buf0 [DEPTH];
    logic [SYS_DWIDTH-1:0] store_buf1 [DEPTH];
    logic [AW:0]           n;
    logic [AW:0]           n_req;
    logic [AW-1:0]         k;
    logic [AW-1:0]         k_next;
    logic                  last;
    logic [SYS_DWIDTH-1:0] rd_word;
    always_comb begin
        n_req   = bus.Cycle_Count > DEPTH_N ? DEPTH_N : bus.Cycle_Count;
        k_next  = k + AW'(1);
        last    = ({1'b0, k} + (AW+1)'(1)) == n;
        rd_word = bus.Host_Sel[1]
                ? (bus.Host_Sel[0] ? store_buf1[bus.Host_Addr] : store_buf0[bus.Host_Addr])
                : (bus.Host_Sel[0] ? load_buf1[bus.Host_Addr]  : load_buf0[bus.Host_Addr]);
    end
    // Buffers carry no reset so a mid-run abort preserves their contents.
    always_ff @(posedge Clk) begin
        if (!Reset && state == IDLE && bus.Host_We && !bus.Host_Sel[1]) begin
            if (bus.Host_Sel[0]) load_buf1[bus.Host_Addr] <= bus.Host_Wdata;
            else load_buf0[bus.Host_Addr] <= bus.Host_Wdata;
        end
        if (!Reset && state == RUN) begin
            store_buf0[k] <= bus.Data0_Store;
            store_buf1[k] <= bus.Data1_Store;
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state             <= IDLE;
            n                 <= '0;
            k                 <= '0;
            bus.Done          <= 1'b0;
            bus.PE_Array_Busy <= 1'b0;
            bus.Data0_Load    <= '0;
            bus.Data1_Load    <= '0;
            bus.Host_Rdata    <= '0;
        end else begin
            bus.Host_Rdata <= rd_word;
            bus.Done       <= 1'b0;
            case (state)
                IDLE: if (bus.Start) begin
                    n <= n_req;
                    k <= '0;
                    if (n_req != '0) begin
                        state             <= RUN;
                        bus.PE_Array_Busy <= 1'b1;
                        bus.Data0_Load    <= load_buf0[0];
                        bus.Data1_Load    <= load_buf1[0];
                    end else begin
                        state    <= DONE;
                        bus.Done <= 1'b1;
                    end
                end
                RUN: if (last) begin
                    state             <= DONE;
                    bus.PE_Array_Busy <= 1'b0;
                    bus.Done          <= 1'b1;
                    bus.Data0_Load    <= '0;
                    bus.Data1_Load    <= '0;
                end else begin
                    k              <= k_next;
                    bus.Data0_Load <= load_buf0[k_next];
                    bus.Data1_Load <= load_buf1[k_next];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_array_io_ctrl.sv
// tb_array_io_ctrl: directed runs against a queue-based model of the run schedule and buffers.
module tb_array_io_ctrl;
    localparam logic [31:0] K1 = 32'h5A5A_0000;
    typedef struct {
        logic        busy;
        logic        done;
        logic [31:0] d0;
        logic [31:0] d1;
        int          idx;
    } ent_t;
    logic Clk;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    array_io_ctrl_if bus ();
    array_io_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    assign bus.Data0_Store = bus.Data0_Load + 32'd1;
    assign bus.Data1_Store = bus.Data1_Load ^ K1;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic [31:0] m_buf [4][256];
    bit          m_vld [4][256];
    ent_t        q [$];
    ent_t        cur = '{1'b0, 1'b0, 32'd0, 32'd0, 0};
    logic [31:0] er = '0;
    bit          erv = 1'b0;
    bit          started = 1'b0;
    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    // Model: an accepted Start schedules N busy cycles then one done cycle.
    always @(posedge Clk) begin
        ent_t        idle_e;
        logic [31:0] f0, f1;
        int          n;
        idle_e = '{1'b0, 1'b0, 32'd0, 32'd0, 0};
        started = 1'b1;
        if (Reset) begin
            q.delete();
            cur = idle_e;
            er  = '0;
            erv = 1'b1;
        end else begin
            erv = m_vld[bus.Host_Sel][bus.Host_Addr];
            er  = m_buf[bus.Host_Sel][bus.Host_Addr];
            if (cur.busy) begin
                m_buf[2][cur.idx] = cur.d0 + 32'd1;
                m_buf[3][cur.idx] = cur.d1 ^ K1;
                m_vld[2][cur.idx] = 1'b1;
                m_vld[3][cur.idx] = 1'b1;
            end
            f0 = m_buf[0][0];
            f1 = m_buf[1][0];
            if (!cur.busy && !cur.done) begin
                if (bus.Host_We && !bus.Host_Sel[1]) begin
                    m_buf[bus.Host_Sel][bus.Host_Addr] = bus.Host_Wdata;
                    m_vld[bus.Host_Sel][bus.Host_Addr] = 1'b1;
                end
                if (bus.Start) begin
                    n = bus.Cycle_Count > 9'd256 ? 256 : int'(bus.Cycle_Count);
                    for (int i = 0; i < n; i++)
                        q.push_back('{1'b1, 1'b0, i == 0 ? f0 : m_buf[0][i], i == 0 ? f1 : m_buf[1][i], i});
                    q.push_back('{1'b0, 1'b1, 32'd0, 32'd0, 0});
                end
            end
            cur = q.size() != 0 ? q.pop_front() : idle_e;
        end
    end
    always @(negedge Clk) if (started) begin
        cmp("busy", 32'(bus.PE_Array_Busy), 32'(cur.busy));
        cmp("done", 32'(bus.Done), 32'(cur.done));
        cmp("data0_load", bus.Data0_Load, cur.d0);
        cmp("data1_load", bus.Data1_Load, cur.d1);
        if (erv) cmp("host_rdata", bus.Host_Rdata, er);
    end
    task automatic wr(input logic [1:0] sel, input int addr, input logic [31:0] data);
        bus.Host_We = 1'b1; bus.Host_Sel = sel; bus.Host_Addr = 8'(addr); bus.Host_Wdata = data;
        @(negedge Clk);
        bus.Host_We = 1'b0;
    endtask
    task automatic go(input logic [8:0] cc);
        bus.Start = 1'b1; bus.Cycle_Count = cc;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask
    task automatic rd(input string name, input logic [1:0] sel, input int addr, input logic [31:0] exp);
        bus.Host_Sel = sel; bus.Host_Addr = 8'(addr);
        @(negedge Clk);
        cmp(name, bus.Host_Rdata, exp);
    endtask
    task automatic wait_done(input string name, input int limit, input int exp_busy);
        bit found = 1'b0;
        int cnt = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.Done) begin found = 1'b1; break; end
            if (bus.PE_Array_Busy) cnt++;
            @(negedge Clk);
        end
        cmp({name, "_done_seen"}, 32'(found), 32'd1);
        cmp({name, "_busy_cycles"}, cnt, exp_busy);
    endtask
    initial begin
        int dcnt;
        Reset = 1'b1; bus.Start = 1'b1; bus.Cycle_Count = 9'd4;
        bus.Host_We = 1'b0; bus.Host_Sel = 2'd0; bus.Host_Addr = '0; bus.Host_Wdata = '0;
        repeat (3) @(negedge Clk);
        cmp("rst_busy", 32'(bus.PE_Array_Busy), 32'd0);
        cmp("rst_done", 32'(bus.Done), 32'd0);
        cmp("rst_load0", bus.Data0_Load, 32'd0);
        cmp("rst_rdata", bus.Host_Rdata, 32'd0);
        Reset = 1'b0; bus.Start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wr(2'd0, i, 32'h100 + 32'(i));
            wr(2'd1, i, 32'h200 + 32'(i));
        end
        wr(2'd2, 5, 32'hBAD0);
        go(9'd4);
        for (int i = 0; i < 4; i++) begin
            cmp("run4_busy", 32'(bus.PE_Array_Busy), 32'd1);
            cmp("run4_load0", bus.Data0_Load, 32'h100 + 32'(i));
            cmp("run4_load1", bus.Data1_Load, 32'h200 + 32'(i));
            @(negedge Clk);
        end
        cmp("run4_busy_fall", 32'(bus.PE_Array_Busy), 32'd0);
        cmp("run4_done", 32'(bus.Done), 32'd1);
        @(negedge Clk);
        cmp("run4_done_pulse", 32'(bus.Done), 32'd0);
        for (int i = 0; i < 4; i++) rd("run4_store0", 2'd2, i, 32'h101 + 32'(i));
        rd("run4_store1", 2'd3, 3, 32'h203 ^ K1);
        go(9'd300);
        wait_done("sat", 400, 256);
        @(negedge Clk);
        rd("sat_store0_255", 2'd2, 255, 32'h200);
        rd("sat_store1_255", 2'd3, 255, 32'h2FF ^ K1);
        rd("sat_store0_128", 2'd2, 128, 32'h181);
        go(9'd0);
        cmp("zero_done", 32'(bus.Done), 32'd1);
        cmp("zero_busy", 32'(bus.PE_Array_Busy), 32'd0);
        @(negedge Clk);
        cmp("zero_done_pulse", 32'(bus.Done), 32'd0);
        rd("zero_store0_0", 2'd2, 0, 32'h101);
        rd("zero_store0_5", 2'd2, 5, 32'h106);
        go(9'd6);
        bus.Host_We = 1'b1; bus.Host_Sel = 2'd0; bus.Host_Addr = '0; bus.Host_Wdata = 32'hDEAD;
        bus.Start = 1'b1; bus.Cycle_Count = 9'd3;
        @(negedge Clk);
        bus.Host_We = 1'b0; bus.Start = 1'b0;
        wait_done("ign", 20, 5);
        dcnt = 0;
        repeat (8) begin
            @(negedge Clk);
            if (bus.Done) dcnt++;
        end
        cmp("ign_extra_done", dcnt, 0);
        rd("ign_load0_0", 2'd0, 0, 32'h100);
        for (int i = 0; i < 8; i++) wr(2'd0, i, 32'h300 + 32'(i));
        go(9'd8);
        repeat (2) @(negedge Clk);
        cmp("abort_k2_load0", bus.Data0_Load, 32'h302);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        cmp("abort_busy", 32'(bus.PE_Array_Busy), 32'd0);
        cmp("abort_load0", bus.Data0_Load, 32'd0);
        cmp("abort_load1", bus.Data1_Load, 32'd0);
        dcnt = 0;
        repeat (6) begin
            if (bus.Done) dcnt++;
            @(negedge Clk);
        end
        cmp("abort_no_done", dcnt, 0);
        rd("abort_store0_0", 2'd2, 0, 32'h301);
        rd("abort_store0_1", 2'd2, 1, 32'h302);
        rd("abort_store0_2", 2'd2, 2, 32'h103);
        rd("abort_store0_7", 2'd2, 7, 32'h108);
        rd("abort_store1_2", 2'd3, 2, 32'h202 ^ K1);
        repeat (2) @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
